pid_core_param: RTL and testbench



---
 rtl/pid_core_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pid_core_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core_param.sv
// pid_core_param: runtime-programmable PID controller with one shared multiplier.
// A 5-state FSM (IDLE -> P -> I -> D -> SUM) runs the P, I and D products
// through the same multiplier. The integrator saturates, anti-windup is
// conditional integration, and the output is clamped to [OUT_MIN, OUT_MAX].
// Optional build macro: PID_RATE_LIMIT_EN limits the output step per sample
// to RATE_MAX.
module pid_core_param #(
    parameter int DW       = 8,
    parameter int GW       = 8,
    parameter int FRAC     = 0,
    parameter int IW       = 16,
    parameter int OUT_MIN  = 0,
    parameter int OUT_MAX  = 2**DW-1,
    parameter int RATE_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gain_we,
    input  logic [1:0]    gain_sel,
    input  logic [GW-1:0] gain_wdata,
    input  logic          int_clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] setpoint,
    input  logic [DW-1:0] feedback,
    output logic          out_valid,
    output logic [DW-1:0] control_signal,
    output logic [1:0]    sat_flag
);

    // Error width, multiplier operand-B width (holds error differences),
    // product width, integrator accumulate width and final sum width.
    localparam int EW = DW + 1;
    localparam int BW = DW + 2;
    localparam int PW = GW + BW;
    localparam int AW = ((IW > PW) ? IW : PW) + 1;
    localparam int SW = IW + GW + 2;

    localparam logic signed [GW-1:0] KP_RST = GW'(32'sd1 <<< FRAC);
    localparam logic signed [IW-1:0] IMAX   = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] IMIN   = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [AW-1:0] IMAX_A = AW'(IMAX);
    localparam logic signed [AW-1:0] IMIN_A = AW'(IMIN);
    localparam logic signed [SW-1:0] OMAX_S = SW'(OUT_MAX);
    localparam logic signed [SW-1:0] OMIN_S = SW'(OUT_MIN);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P    = 3'd1,
        ST_I    = 3'd2,
        ST_D    = 3'd3,
        ST_SUM  = 3'd4
    } state_t;

    // Saturate a wide accumulator value into the signed integrator range.
    function automatic logic signed [IW-1:0] sat_int(input logic signed [AW-1:0] v);
        if (v > IMAX_A) begin
            return IMAX;
        end else if (v < IMIN_A) begin
            return IMIN;
        end else begin
            return v[IW-1:0];
        end
    endfunction

    state_t                 state_r, state_nx_s;
    logic signed [GW-1:0]   kp_r, ki_r, kd_r;
    logic signed [GW-1:0]   kp_snap_r, ki_snap_r, kd_snap_r;
    logic signed [EW-1:0]   err_r, prev_err_r, err_in_s;
    logic signed [PW-1:0]   p_r, d_r, prod_s;
    logic signed [IW-1:0]   int_r, int_nx_s;
    logic signed [AW-1:0]   acc_s;
    logic signed [GW-1:0]   mul_a_s;
    logic signed [BW-1:0]   mul_b_s;
    logic signed [SW-1:0]   sum_s, sum_sh_s;
    logic [DW-1:0]          clamp_s, cs_nx_s, cs_r;
    logic [1:0]             sat_nx_s, sat_r;
    logic                   out_valid_r;
    logic                   accept_s;
    logic                   skip_int_s;

    assign in_ready       = (state_r == ST_IDLE);
    assign out_valid      = out_valid_r;
    assign control_signal = cs_r;
    assign sat_flag       = sat_r;
    assign accept_s       = in_valid & (state_r == ST_IDLE);
    assign err_in_s       = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state sequencing: one edge per computation phase.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_P;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_P:    state_nx_s = ST_I;
            ST_I:    state_nx_s = ST_D;
            ST_D:    state_nx_s = ST_SUM;
            ST_SUM:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Shared multiplier operand selection by phase.
    always_comb begin
        mul_a_s = kp_snap_r;
        mul_b_s = BW'(err_r);
        case (state_r)
            ST_P: begin
                mul_a_s = kp_snap_r;
                mul_b_s = BW'(err_r);
            end
            ST_I: begin
                mul_a_s = ki_snap_r;
                mul_b_s = BW'(err_r);
            end
            ST_D: begin
                mul_a_s = kd_snap_r;
                mul_b_s = BW'(err_r) - BW'(prev_err_r);
            end
            default: begin
                mul_a_s = kp_snap_r;
                mul_b_s = BW'(err_r);
            end
        endcase
    end

    assign prod_s   = PW'(mul_a_s) * PW'(mul_b_s);
    assign acc_s    = AW'(int_r) + AW'(prod_s);
    assign int_nx_s = sat_int(acc_s);

    // Conditional integration: do not push further into the limit the
    // previous output was clamped against.
    assign skip_int_s = (sat_r[1] & ~err_r[EW-1] & (err_r != {EW{1'b0}}))
                      | (sat_r[0] &  err_r[EW-1]);

    assign sum_s    = SW'(p_r) + SW'(int_r) + SW'(d_r);
    assign sum_sh_s = sum_s >>> FRAC;

    // Output clamp against the configured limits.
    always_comb begin
        clamp_s  = sum_sh_s[DW-1:0];
        sat_nx_s = 2'b00;
        if (sum_sh_s > OMAX_S) begin
            clamp_s  = DW'(OUT_MAX);
            sat_nx_s = 2'b10;
        end else if (sum_sh_s < OMIN_S) begin
            clamp_s  = DW'(OUT_MIN);
            sat_nx_s = 2'b01;
        end else begin
            clamp_s  = sum_sh_s[DW-1:0];
            sat_nx_s = 2'b00;
        end
    end

`ifdef PID_RATE_LIMIT_EN
    logic [DW+1:0] rl_prev_s, rl_new_s, rl_step_s, rl_up_s, rl_dn_s;

    // Limit the step between the held output and the new clamped value.
    always_comb begin
        rl_prev_s = {2'b00, cs_r};
        rl_new_s  = {2'b00, clamp_s};
        rl_step_s = (DW+2)'(RATE_MAX);
        rl_up_s   = rl_prev_s + rl_step_s;
        rl_dn_s   = rl_prev_s - rl_step_s;
        if (rl_new_s > rl_up_s) begin
            cs_nx_s = rl_up_s[DW-1:0];
        end else if ((rl_new_s + rl_step_s) < rl_prev_s) begin
            cs_nx_s = rl_dn_s[DW-1:0];
        end else begin
            cs_nx_s = clamp_s;
        end
    end
`else
    // RATE_MAX has no effect in this build.
    logic [31:0] rate_unused_s;
    assign rate_unused_s = RATE_MAX;
    assign cs_nx_s       = clamp_s;
`endif

    // Gain registers (writable any time) and per-sample snapshots.
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_r      <= KP_RST;
            ki_r      <= {GW{1'b0}};
            kd_r      <= {GW{1'b0}};
            kp_snap_r <= KP_RST;
            ki_snap_r <= {GW{1'b0}};
            kd_snap_r <= {GW{1'b0}};
        end else begin
            if (gain_we) begin
                case (gain_sel)
                    2'd0:    kp_r <= gain_wdata;
                    2'd1:    ki_r <= gain_wdata;
                    2'd2:    kd_r <= gain_wdata;
                    default: kp_r <= kp_r;
                endcase
            end
            if (accept_s) begin
                kp_snap_r <= kp_r;
                ki_snap_r <= ki_r;
                kd_snap_r <= kd_r;
            end
        end
    end

    // Sample capture and P/I/D phase results.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r      <= {EW{1'b0}};
            prev_err_r <= {EW{1'b0}};
            p_r        <= {PW{1'b0}};
            d_r        <= {PW{1'b0}};
            int_r      <= {IW{1'b0}};
        end else begin
            if (accept_s) begin
                err_r <= err_in_s;
            end
            if (state_r == ST_P) begin
                p_r <= prod_s;
            end
            if (int_clear) begin
                int_r <= {IW{1'b0}};
            end else if ((state_r == ST_I) && !skip_int_s) begin
                int_r <= int_nx_s;
            end
            if (state_r == ST_D) begin
                d_r        <= prod_s;
                prev_err_r <= err_r;
            end
        end
    end

    // Registered result, saturation flags and one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            cs_r        <= {DW{1'b0}};
            sat_r       <= 2'b00;
        end else begin
            out_valid_r <= (state_r == ST_SUM);
            if (state_r == ST_SUM) begin
                cs_r  <= cs_nx_s;
                sat_r <= sat_nx_s;
            end
        end
    end

endmodule

// File: tb/tb_pid_core_param.sv
// Directed testbench for pid_core_param (default build, FRAC=0).
module tb_pid_core_param;

    localparam int DW = 8;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gain_we = 1'b0;
    logic [1:0]    gain_sel = 2'd0;
    logic [GW-1:0] gain_wdata = '0;
    logic          int_clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] setpoint = '0;
    logic [DW-1:0] feedback = '0;
    logic          out_valid;
    logic [DW-1:0] control_signal;
    logic [1:0]    sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pid_core_param dut (
        .clk            (clk),
        .rst            (rst),
        .gain_we        (gain_we),
        .gain_sel       (gain_sel),
        .gain_wdata     (gain_wdata),
        .int_clear      (int_clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .setpoint       (setpoint),
        .feedback       (feedback),
        .out_valid      (out_valid),
        .control_signal (control_signal),
        .sat_flag       (sat_flag)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        gain_we   = 1'b0;
        int_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        check_val({tag, "_ov"},  32'(out_valid), 32'd0);
        check_val({tag, "_cs"},  32'(control_signal), 32'd0);
        check_val({tag, "_sat"}, 32'(sat_flag), 32'd0);
    endtask

    task automatic write_gain(input logic [1:0] sel, input logic [GW-1:0] val);
        @(negedge clk);
        gain_we    = 1'b1;
        gain_sel   = sel;
        gain_wdata = val;
        @(negedge clk);
        gain_we = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic [DW-1:0] sp, input logic [DW-1:0] fb,
                              input int exp_cs, input int exp_sat);
        int n;
        bit seen;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        setpoint = sp;
        feedback = fb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = out_valid;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd4);
        check_val({tag, "_cs"},  32'(control_signal), 32'(exp_cs));
        check_val({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
        @(posedge clk);
        #1;
        check_val({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;

        // Defaults, clamp low, clamp high.
        do_reset("rst0");
        run_sample("def",  8'd100, 8'd40,  60,  0);
        run_sample("lo",   8'd40,  8'd100, 0,   1);
        write_gain(2'd0, 8'd2);
        run_sample("hi",   8'd255, 8'd0,   255, 2);

        // Integral accumulation and clear.
        do_reset("rst1");
        write_gain(2'd0, 8'd0);
        write_gain(2'd1, 8'd2);
        run_sample("int1", 8'd50, 8'd45, 10, 0);
        run_sample("int2", 8'd50, 8'd45, 20, 0);
        run_sample("int3", 8'd50, 8'd45, 30, 0);
        run_sample("int4", 8'd50, 8'd45, 40, 0);
        @(negedge clk);
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
        run_sample("intc", 8'd50, 8'd45, 10, 0);

        // Derivative term.
        do_reset("rst2");
        write_gain(2'd0, 8'd0);
        write_gain(2'd2, 8'd3);
        run_sample("der1", 8'd20, 8'd10, 30, 0);
        run_sample("der2", 8'd30, 8'd20, 0,  0);
        run_sample("der3", 8'd40, 8'd20, 30, 0);
        do_reset("rst3");
        write_gain(2'd0, 8'd0);
        write_gain(2'd2, 8'd3);
        run_sample("der4", 8'd15, 8'd10, 15, 0);

        // Anti-windup.
        do_reset("rst4");
        write_gain(2'd0, 8'd0);
        write_gain(2'd1, 8'd100);
        run_sample("aw1", 8'd20, 8'd10, 255, 2);
        run_sample("aw2", 8'd20, 8'd10, 255, 2);
        run_sample("aw3", 8'd10, 8'd20, 0,   0);

        // Handshake: in_valid held while busy, gain write mid-sample.
        do_reset("rst5");
        @(negedge clk);
        setpoint = 8'd100;
        feedback = 8'd40;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("hs_busy%0d", k), 32'(in_ready), 32'd0);
            if (k == 0) begin
                setpoint = 8'd200;
                feedback = 8'd0;
            end
            if (k == 1) begin
                gain_we    = 1'b1;
                gain_sel   = 2'd0;
                gain_wdata = 8'd2;
            end
            if (k == 2) begin
                gain_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check_val("hs_ov",  32'(out_valid), 32'd1);
        check_val("hs_cs",  32'(control_signal), 32'd60);
        check_val("hs_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check_val("hs_stray", 32'(stray), 32'd0);
        check_val("hs_hold",  32'(control_signal), 32'd60);
        run_sample("hs_gain", 8'd100, 8'd40, 120, 0);

        // Reset while in the D phase aborts the sample.
        do_reset("rst6");
        run_sample("rd_pre", 8'd100, 8'd40, 60, 0);
        @(negedge clk);
        setpoint = 8'd50;
        feedback = 8'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("rd_ov",  32'(out_valid), 32'd0);
        check_val("rd_cs",  32'(control_signal), 32'd0);
        check_val("rd_rdy", 32'(in_ready), 32'd1);
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check_val("rd_stray", 32'(stray), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
